// File: rtl/mcp_rx_pkg.sv
// Shared constants for the MCP receive FIFO slice.
// Only the optional drop counter (MCP_RX_FIFO_DROP_COUNT_EN) uses these.
package mcp_rx_pkg;

  localparam int unsigned DROP_COUNT_W = 16;
  localparam logic [DROP_COUNT_W-1:0] DROP_COUNT_MAX = '1;

endpackage

// File: rtl/mcp_rx_ptr.sv
// Wrapping FIFO pointer: one extra MSB distinguishes full from empty.
module mcp_rx_ptr #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  output logic [W-1:0] ptr
);

  logic [W-1:0] ptr_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr_q <= '0;
    end else if (en) begin
      ptr_q <= ptr_q + W'(1);
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/mcp_rx_fifo.sv
// FWFT receive buffer behind the multi-cycle-path CDC stage; drops and flags overflow.
// Define MCP_RX_FIFO_DROP_COUNT_EN to add the saturating drop_count output.
module mcp_rx_fifo
  import mcp_rx_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [WIDTH-1:0]        b_data,
  input  logic                    b_load,
  output logic [WIDTH-1:0]        m_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [PTR_W:0]          level,
  output logic                    overflow,
  input  logic                    overflow_clr
`ifdef MCP_RX_FIFO_DROP_COUNT_EN
  ,
  output logic [DROP_COUNT_W-1:0] drop_count
`endif
);

  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic             empty;
  logic             full;
  logic             push;
  logic             pop;
  logic             drop;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             overflow_q;

  mcp_rx_ptr #(
    .W(PTR_W + 1)
  ) u_wr_ptr (
    .clk    (clk),
    .reset_n(reset_n),
    .en     (push),
    .ptr    (wr_ptr)
  );

  mcp_rx_ptr #(
    .W(PTR_W + 1)
  ) u_rd_ptr (
    .clk    (clk),
    .reset_n(reset_n),
    .en     (pop),
    .ptr    (rd_ptr)
  );

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]) && (wr_ptr[PTR_W] != rd_ptr[PTR_W]);
  assign pop   = !empty && m_ready;
  // A pop frees the head slot this cycle, so a full queue may still accept a write.
  assign push  = b_load && (!full || pop);
  assign drop  = b_load && full && !pop;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr[PTR_W-1:0]] <= b_data;
    end
  end

  assign m_data  = mem_q[rd_ptr[PTR_W-1:0]];
  assign m_valid = !empty;
  assign level   = wr_ptr - rd_ptr;

  // Set has priority over clear so a drop in the clear cycle is never hidden.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      overflow_q <= 1'b0;
    end else if (drop) begin
      overflow_q <= 1'b1;
    end else if (overflow_clr) begin
      overflow_q <= 1'b0;
    end
  end

  assign overflow = overflow_q;

`ifdef MCP_RX_FIFO_DROP_COUNT_EN
  logic [DROP_COUNT_W-1:0] drop_count_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      drop_count_q <= '0;
    end else if (overflow_clr) begin
      drop_count_q <= drop ? DROP_COUNT_W'(1) : '0;
    end else if (drop && (drop_count_q != DROP_COUNT_MAX)) begin
      drop_count_q <= drop_count_q + DROP_COUNT_W'(1);
    end
  end

  assign drop_count = drop_count_q;
`endif

endmodule
